// File: rtl/fp_mul_pipe_if.sv
// Stream bundle for fp_mul_pipe: operand channel in, product channel out,
// plus per-result and sticky exception flags.
interface fp_mul_pipe_if #(
    parameter int WIDTH = 18
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [3:0]       out_flags;
    logic             flags_clr;
    logic [3:0]       sticky_flags;

    modport slave (
        input  in_valid, a, b, out_ready, flags_clr,
        output in_ready, out_valid, out, out_flags, sticky_flags
    );

    modport master (
        output in_valid, a, b, out_ready, flags_clr,
        input  in_ready, out_valid, out, out_flags, sticky_flags
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier (decode, multiply, normalise/round/pack)
// with valid/ready flow control, special-case handling and sticky flags.
module fp_mul_pipe #(
    parameter int EXPONENT = 8,
    parameter int MANTISSA = 9,
    parameter int ROUND    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_mul_pipe_if.slave  bus
);
    localparam int WIDTH = EXPONENT + MANTISSA + 1;
    localparam int SW    = 2 * MANTISSA + 2;
    localparam int XW    = EXPONENT + 2;
    localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EXPONENT - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_INF  = XW'((1 << EXPONENT) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;

    typedef struct packed {
        logic                sign;
        logic                invalid;
        logic                inf;
        logic                zero;
        logic [EXPONENT-1:0] ea;
        logic [EXPONENT-1:0] eb;
        logic [MANTISSA:0]   ma;
        logic [MANTISSA:0]   mb;
    } s1_t;

    typedef struct packed {
        logic                 sign;
        logic                 invalid;
        logic                 inf;
        logic                 zero;
        logic signed [XW-1:0] exp;
        logic [SW-1:0]        prod;
    } s2_t;

    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       sticky_q, sticky_d;
    logic             en1, en2, en3;

    // A stage may load when it is empty or its content moves on this cycle.
    assign en3 = !v3_q || bus.out_ready;
    assign en2 = !v2_q || en3;
    assign en1 = !v1_q || en2;

    assign bus.in_ready     = en1;
    assign bus.out_valid    = v3_q;
    assign bus.out          = out_q;
    assign bus.out_flags    = flags_q;
    assign bus.sticky_flags = sticky_q;

    logic [WIDTH-1:0]    opnd [2];
    logic [1:0]          dec_sign, dec_zero, dec_inf, dec_nan;
    logic [EXPONENT-1:0] dec_exp [2];
    logic [MANTISSA:0]   dec_man [2];

    assign opnd[0] = bus.a;
    assign opnd[1] = bus.b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            logic [EXPONENT-1:0] ef;
            logic [MANTISSA-1:0] ff;
            assign ef           = opnd[gi][WIDTH-2 -: EXPONENT];
            assign ff           = opnd[gi][MANTISSA-1:0];
            assign dec_sign[gi] = opnd[gi][WIDTH-1];
            // Subnormals share the zero class: flushed, no flag.
            assign dec_zero[gi] = (ef == '0);
            assign dec_inf[gi]  = (ef == '1) && (ff == '0);
            assign dec_nan[gi]  = (ef == '1) && (ff != '0);
            assign dec_exp[gi]  = ef;
            assign dec_man[gi]  = {1'b1, ff};
        end
    endgenerate

    // Normalise / round / pack from the multiply stage.
    logic [SW-1:0]        sh;
    logic                 norm, guard, sticky_b, inc;
    logic [MANTISSA-1:0]  frac;
    logic [MANTISSA:0]    frac_r;
    logic signed [XW-1:0] one_n, one_c, exp_f;
    logic [WIDTH-1:0]     res;
    logic [3:0]           res_flags;

    always_comb begin
        norm      = s2_q.prod[SW-1];
        sh        = norm ? s2_q.prod : (s2_q.prod << 1);
        frac      = sh[SW-2 -: MANTISSA];
        guard     = sh[MANTISSA];
        sticky_b  = |sh[MANTISSA-1:0];
        inc       = (ROUND != 0) && guard && (sticky_b || frac[0]);
        frac_r    = {1'b0, frac} + {{MANTISSA{1'b0}}, inc};
        one_n     = {{(XW-1){1'b0}}, norm};
        one_c     = {{(XW-1){1'b0}}, frac_r[MANTISSA]};
        exp_f     = $signed(s2_q.exp) + one_n + one_c;
        res       = {s2_q.sign, exp_f[EXPONENT-1:0], frac_r[MANTISSA-1:0]};
        res_flags = {3'b000, guard | sticky_b};
        if (s2_q.invalid) begin
            res       = {1'b1, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};
            res_flags = 4'b1000;
        end else if (s2_q.inf) begin
            res       = {s2_q.sign, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
            res_flags = 4'b0000;
        end else if (s2_q.zero) begin
            res       = {s2_q.sign, {(WIDTH-1){1'b0}}};
            res_flags = 4'b0000;
        end else if (exp_f >= EXP_INF) begin
            res       = {s2_q.sign, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
            res_flags = 4'b0101;
        end else if (exp_f <= EXP_ZERO) begin
            res       = {s2_q.sign, {(WIDTH-1){1'b0}}};
            res_flags = 4'b0011;
        end
    end

    always_comb begin
        v1_d     = v1_q;
        v2_d     = v2_q;
        v3_d     = v3_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        out_d    = out_q;
        flags_d  = flags_q;
        if (en1) begin
            v1_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d.sign    = dec_sign[0] ^ dec_sign[1];
                s1_d.invalid = (|dec_nan) || (dec_inf[0] && dec_zero[1])
                                          || (dec_zero[0] && dec_inf[1]);
                s1_d.inf     = |dec_inf;
                s1_d.zero    = |dec_zero;
                s1_d.ea      = dec_exp[0];
                s1_d.eb      = dec_exp[1];
                s1_d.ma      = dec_man[0];
                s1_d.mb      = dec_man[1];
            end
        end
        if (en2) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2_d.sign    = s1_q.sign;
                s2_d.invalid = s1_q.invalid;
                s2_d.inf     = s1_q.inf;
                s2_d.zero    = s1_q.zero;
                s2_d.exp     = $signed({2'b00, s1_q.ea}) + $signed({2'b00, s1_q.eb}) - BIAS;
                s2_d.prod    = SW'(s1_q.ma) * SW'(s1_q.mb);
            end
        end
        if (en3) begin
            v3_d = v2_q;
            if (v2_q) begin
                out_d   = res;
                flags_d = res_flags;
            end
        end
        // A coincident handshake's flags survive a clear.
        sticky_d = (bus.flags_clr ? 4'b0000 : sticky_q)
                 | ((v3_q && bus.out_ready) ? flags_q : 4'b0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            out_q    <= '0;
            flags_q  <= '0;
            sticky_q <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            out_q    <= out_d;
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
        end
    end
endmodule
